// File: rtl/cnn_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// cnn_stage_sequencer_if
// Handshake and stage-control bundle between a frame host and the
// cnn_stage_sequencer.
//   start       host -> seq  frame start request
//   abort       host -> seq  synchronous abort back to IDLE
//   stage_rst   seq -> host  per-stage active-high resets (bit0=C1 .. bit5=MP2)
//   en_relu     seq -> host  ReLU enable
//   stage_idx   seq -> host  index of the active stage (0-5)
//   busy        seq -> host  frame in progress
//   frame_done  seq -> host  one-cycle frame completion pulse
// Optional (CNN_SEQ_DONE_HS_EN defined):
//   stage_done  host -> seq  per-stage completion flags
//   timeout_err seq -> host  sticky watchdog flag
// modport master: frame host side; modport slave: sequencer side.
// ---------------------------------------------------------------------------
interface cnn_stage_sequencer_if;
  logic       start;
  logic       abort;
  logic [5:0] stage_rst;
  logic       en_relu;
  logic [2:0] stage_idx;
  logic       busy;
  logic       frame_done;
`ifdef CNN_SEQ_DONE_HS_EN
  logic [5:0] stage_done;
  logic       timeout_err;

  modport master (
    output start, abort, stage_done,
    input  stage_rst, en_relu, stage_idx, busy, frame_done, timeout_err
  );

  modport slave (
    input  start, abort, stage_done,
    output stage_rst, en_relu, stage_idx, busy, frame_done, timeout_err
  );
`else
  modport master (
    output start, abort,
    input  stage_rst, en_relu, stage_idx, busy, frame_done
  );

  modport slave (
    input  start, abort,
    output stage_rst, en_relu, stage_idx, busy, frame_done
  );
`endif
endinterface

// File: rtl/cnn_stage_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_stage_sequencer
// Frame-level controller for the conv1 -> relu1 -> maxpool1 -> conv2 ->
// relu2 -> maxpool2 front end. A start request releases the stage resets one
// by one, each stage owning a programmable cycle budget. After the last stage
// all stages remain released (final pooled output stays valid) until the next
// start (which inserts a one-cycle flush with every stage held in reset) or an
// abort.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    cnn_stage_sequencer_if.slave (start, abort, stage_rst, en_relu,
//          stage_idx, busy, frame_done [, stage_done, timeout_err])
// Optional feature macro: CNN_SEQ_DONE_HS_EN -- a stage also advances early on
// its stage_done bit; budget expiry without it raises the sticky timeout_err.
// All outputs are registered.
// ---------------------------------------------------------------------------
module cnn_stage_sequencer #(
  parameter int CNT_W      = 24,
  parameter int C1_CYCLES  = 10199,
  parameter int R1_CYCLES  = 28224,
  parameter int MP1_CYCLES = 8,
  parameter int C2_CYCLES  = 60192,
  parameter int R2_CYCLES  = 9600,
  parameter int MP2_CYCLES = 20
) (
  input logic                 clk,
  input logic                 reset,
  cnn_stage_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] RST_ALL  = 6'b111111;
  localparam logic [2:0] LAST_IDX = 3'd5;
  localparam longint     B_LIMIT  = longint'(1) << CNT_W;

  // Every budget must fit the counter, otherwise a stage could never expire.
  if ((CNT_W < 1) || (CNT_W > 32) ||
      (C1_CYCLES < 0)  || (longint'(C1_CYCLES)  >= B_LIMIT) ||
      (R1_CYCLES < 0)  || (longint'(R1_CYCLES)  >= B_LIMIT) ||
      (MP1_CYCLES < 0) || (longint'(MP1_CYCLES) >= B_LIMIT) ||
      (C2_CYCLES < 0)  || (longint'(C2_CYCLES)  >= B_LIMIT) ||
      (R2_CYCLES < 0)  || (longint'(R2_CYCLES)  >= B_LIMIT) ||
      (MP2_CYCLES < 0) || (longint'(MP2_CYCLES) >= B_LIMIT)) begin : g_budget_check
    $error("cnn_stage_sequencer: stage budget does not fit in CNT_W bits");
  end

  // Terminal count of a stage; a zero budget behaves as one cycle.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [2:0] i);
    logic [CNT_W-1:0] b;
    case (i)
      3'd0:    b = CNT_W'(C1_CYCLES);
      3'd1:    b = CNT_W'(R1_CYCLES);
      3'd2:    b = CNT_W'(MP1_CYCLES);
      3'd3:    b = CNT_W'(C2_CYCLES);
      3'd4:    b = CNT_W'(R2_CYCLES);
      default: b = CNT_W'(MP2_CYCLES);
    endcase
    if (b == {CNT_W{1'b0}}) begin
      last_cnt = {CNT_W{1'b0}};
    end else begin
      last_cnt = b - CNT_W'(1);
    end
  endfunction

  // Thermometer reset pattern with stages 0..i released.
  function automatic logic [5:0] rst_pattern(input logic [2:0] i);
    rst_pattern = RST_ALL << ({1'b0, i} + 4'd1);
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [5:0]       stage_rst_r, stage_rst_s;
  logic             en_relu_r, en_relu_s;
  logic             busy_r, busy_s;
  logic             frame_done_r, frame_done_s;
  logic             expire_s;
  logic             advance_s;
`ifdef CNN_SEQ_DONE_HS_EN
  logic             timeout_r, timeout_s;
  logic [7:0]       done_ext_s;
  logic             hs_done_s;
`endif

  // Stage advance condition: budget expiry, or the active stage's done flag.
  always_comb begin
    expire_s = (cnt_r == last_cnt(idx_r));
`ifdef CNN_SEQ_DONE_HS_EN
    done_ext_s = {2'b00, bus.stage_done};
    hs_done_s  = done_ext_s[idx_r];
    advance_s  = expire_s | hs_done_s;
`else
    advance_s  = expire_s;
`endif
  end

  // Next-state and next-output logic; abort overrides start and advance.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    idx_s        = idx_r;
    stage_rst_s  = stage_rst_r;
    en_relu_s    = en_relu_r;
    busy_s       = busy_r;
    frame_done_s = 1'b0;
`ifdef CNN_SEQ_DONE_HS_EN
    timeout_s    = timeout_r;
`endif
    if (bus.abort) begin
      state_s     = IDLE;
      cnt_s       = {CNT_W{1'b0}};
      idx_s       = 3'd0;
      stage_rst_s = RST_ALL;
      en_relu_s   = 1'b0;
      busy_s      = 1'b0;
`ifdef CNN_SEQ_DONE_HS_EN
      timeout_s   = 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_s     = RUN;
            cnt_s       = {CNT_W{1'b0}};
            idx_s       = 3'd0;
            stage_rst_s = rst_pattern(3'd0);
            en_relu_s   = 1'b1;
            busy_s      = 1'b1;
`ifdef CNN_SEQ_DONE_HS_EN
            timeout_s   = 1'b0;
`endif
          end else begin
            stage_rst_s = RST_ALL;
            en_relu_s   = 1'b0;
            busy_s      = 1'b0;
          end
        end
        FLUSH: begin
          state_s     = RUN;
          cnt_s       = {CNT_W{1'b0}};
          idx_s       = 3'd0;
          stage_rst_s = rst_pattern(3'd0);
          en_relu_s   = 1'b1;
          busy_s      = 1'b1;
        end
        RUN: begin
          if (advance_s) begin
            cnt_s = {CNT_W{1'b0}};
            if (idx_r == LAST_IDX) begin
              state_s      = DONE;
              busy_s       = 1'b0;
              frame_done_s = 1'b1;
            end else begin
              idx_s       = idx_r + 3'd1;
              stage_rst_s = rst_pattern(idx_r + 3'd1);
            end
`ifdef CNN_SEQ_DONE_HS_EN
            // Watchdog: expiry without the stage's own done flag.
            if (expire_s && !hs_done_s) begin
              timeout_s = 1'b1;
            end else begin
              timeout_s = timeout_r;
            end
`endif
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.start) begin
            // One cycle with every stage back in reset before the new frame.
            state_s     = FLUSH;
            cnt_s       = {CNT_W{1'b0}};
            idx_s       = 3'd0;
            stage_rst_s = RST_ALL;
            en_relu_s   = 1'b0;
            busy_s      = 1'b1;
`ifdef CNN_SEQ_DONE_HS_EN
            timeout_s   = 1'b0;
`endif
          end else begin
            stage_rst_s = stage_rst_r;
          end
        end
        default: begin
          state_s     = IDLE;
          cnt_s       = {CNT_W{1'b0}};
          idx_s       = 3'd0;
          stage_rst_s = RST_ALL;
          en_relu_s   = 1'b0;
          busy_s      = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      idx_r        <= 3'd0;
      stage_rst_r  <= RST_ALL;
      en_relu_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef CNN_SEQ_DONE_HS_EN
      timeout_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      idx_r        <= idx_s;
      stage_rst_r  <= stage_rst_s;
      en_relu_r    <= en_relu_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
`ifdef CNN_SEQ_DONE_HS_EN
      timeout_r    <= timeout_s;
`endif
    end
  end

  assign bus.stage_rst  = stage_rst_r;
  assign bus.en_relu    = en_relu_r;
  assign bus.stage_idx  = idx_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
`ifdef CNN_SEQ_DONE_HS_EN
  assign bus.timeout_err = timeout_r;
`endif

endmodule
